// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Instruction-fetch sequencer for a single-cycle-read instruction memory.
// Owns the fetch PC, presents it as the memory address every cycle, and
// buffers each fetched word together with its PC in a small prefetch FIFO.
// The FIFO head is offered to decode over a valid/ready handshake. A
// redirect (branch/jump) flushes the FIFO and reloads the fetch PC.
//
// Optional build feature: define IMEM_DBG_PORT_EN to add a debug read port
// that borrows the memory for one cycle (dbg_req/dbg_addr in,
// dbg_data/dbg_ack out). Without the macro those ports do not exist.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   fetch_en        fetch permitted (0: hold fetch PC, no push)
//   mem_addr        word address to the instruction memory
//   mem_data        read data from the instruction memory (same cycle)
//   redirect_valid  flush queue and load redirect_pc
//   redirect_pc     redirect target
//   instr_valid     queue head valid
//   instr           queue head instruction
//   instr_pc        PC of queue head
//   instr_ready     decode accepts the head
//   dbg_req/dbg_addr/dbg_data/dbg_ack   (IMEM_DBG_PORT_EN only)
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
`ifdef IMEM_DBG_PORT_EN
  ,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ack
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // State
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;

  // Queue storage: one PC and one instruction word per entry
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic push;
  logic pop;
  logic dbg_stall;

  // ---------------------------------------------------------------------------
  // Memory address and debug arbitration
  // ---------------------------------------------------------------------------
`ifdef IMEM_DBG_PORT_EN
  logic [DATA_W-1:0] dbg_data_q;
  logic              dbg_ack_q;

  // A debug request owns the memory for this cycle, so the fetch stream
  // must not consume mem_data and the fetch PC must not advance.
  assign dbg_stall = dbg_req;
  assign mem_addr  = dbg_req ? dbg_addr : fetch_pc_q;
  assign dbg_data  = dbg_data_q;
  assign dbg_ack   = dbg_ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_data_q <= '0;
      dbg_ack_q  <= 1'b0;
    end else begin
      dbg_ack_q <= dbg_req;
      if (dbg_req) begin
        dbg_data_q <= mem_data;
      end
    end
  end
`else
  assign dbg_stall = 1'b0;
  assign mem_addr  = fetch_pc_q;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and queue control
  // ---------------------------------------------------------------------------
  assign instr_valid = (count_q != '0);
  assign instr       = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];

  assign pop = instr_valid & instr_ready;

  // A full queue may still push when the head leaves in the same cycle,
  // which is what sustains one instruction per cycle.
  assign push = fetch_en & ~redirect_valid & ~dbg_stall &
                ((count_q < CNT_W'(DEPTH)) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect_valid) begin
      // Flush wins over everything: the head shown this cycle is squashed.
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (push) begin
        // Natural wrap of the ADDR_W-bit PC gives modulo addressing.
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= ADDR_W'(RESET_PC);
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Queue entries
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q[gi] <= '0;
          pc_q[gi]   <= '0;
        end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
          data_q[gi] <= mem_data;
          pc_q[gi]   <= fetch_pc_q;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [5:0]  mem_addr;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  instr_pc;
  logic        instr_ready;
`ifdef IMEM_DBG_PORT_EN
  logic        dbg_req;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ack;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instruction memory model: distinct, non-zero word per address.
  function automatic logic [31:0] ram_word(input logic [5:0] a);
    return 32'hA5000F0F ^ ({26'd0, a} * 32'h01030507);
  endfunction

  assign mem_data = ram_word(mem_addr);

  imem_fetch_ctrl #(
    .ADDR_W(6), .DATA_W(32), .DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef IMEM_DBG_PORT_EN
    ,
    .dbg_req        (dbg_req),
    .dbg_addr       (dbg_addr),
    .dbg_data       (dbg_data),
    .dbg_ack        (dbg_ack)
`endif
  );

  typedef struct packed {
    logic       fe;
    logic       rdy;
    logic       rv;
    logic [5:0] rpc;
    logic       ev;
    logic [5:0] epc;
    logic [5:0] emaddr;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t mk(input logic fe, rdy, rv, input logic [5:0] rpc,
                              input logic ev, input logic [5:0] epc, emaddr);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.emaddr = emaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    // Each vector describes one cycle: inputs applied during the cycle and
    // the outputs expected before its rising edge.
    vecs[0]  = mk(1, 1, 0, 0,  0, 0,  0);
    vecs[1]  = mk(1, 1, 0, 0,  1, 0,  1);
    vecs[2]  = mk(1, 1, 0, 0,  1, 1,  2);
    vecs[3]  = mk(1, 1, 0, 0,  1, 2,  3);
    vecs[4]  = mk(1, 0, 0, 0,  1, 3,  4);   // stall: queue fills
    vecs[5]  = mk(1, 0, 0, 0,  1, 3,  5);
    vecs[6]  = mk(1, 0, 0, 0,  1, 3,  6);
    vecs[7]  = mk(1, 0, 0, 0,  1, 3,  7);   // full, PC holds
    vecs[8]  = mk(1, 0, 0, 0,  1, 3,  7);
    vecs[9]  = mk(1, 1, 0, 0,  1, 3,  7);   // full + pop still pushes
    vecs[10] = mk(1, 1, 0, 0,  1, 4,  8);
    vecs[11] = mk(1, 1, 1, 32, 1, 5,  9);   // redirect to 0x20
    vecs[12] = mk(1, 1, 0, 0,  0, 0,  32);
    vecs[13] = mk(1, 1, 0, 0,  1, 32, 33);
    vecs[14] = mk(1, 1, 0, 0,  1, 33, 34);
    vecs[15] = mk(1, 1, 1, 62, 1, 34, 35);  // redirect to 62, wrap follows
    vecs[16] = mk(1, 1, 0, 0,  0, 0,  62);
    vecs[17] = mk(1, 1, 0, 0,  1, 62, 63);
    vecs[18] = mk(1, 1, 0, 0,  1, 63, 0);
    vecs[19] = mk(1, 1, 0, 0,  1, 0,  1);
    vecs[20] = mk(0, 1, 0, 0,  1, 1,  2);   // fetch_en=0: drain, hold PC
    vecs[21] = mk(0, 1, 0, 0,  0, 0,  2);
    vecs[22] = mk(1, 1, 0, 0,  0, 0,  2);
    vecs[23] = mk(1, 1, 0, 0,  1, 2,  3);
    vecs[24] = mk(1, 1, 1, 10, 1, 3,  4);   // redirect held two cycles
    vecs[25] = mk(1, 1, 1, 12, 0, 0,  10);
    vecs[26] = mk(1, 1, 0, 0,  0, 0,  12);
    vecs[27] = mk(1, 1, 0, 0,  1, 12, 13);
  end

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
`ifdef IMEM_DBG_PORT_EN
    dbg_req  = 1'b0;
    dbg_addr = '0;
`endif

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset instr_valid", 32'(instr_valid), 32'd0);
    chk("reset instr",       instr,            32'd0);
    chk("reset instr_pc",    32'(instr_pc),    32'd0);
    chk("reset mem_addr",    32'(mem_addr),    32'd0);
`ifdef IMEM_DBG_PORT_EN
    chk("reset dbg_ack",  32'(dbg_ack), 32'd0);
    chk("reset dbg_data", dbg_data,     32'd0);
`endif

    // Table-driven vectors, starting with the cycle reset is released
    rst_n = 1'b1;
    for (int i = 0; i < 28; i++) begin
      fetch_en       = vecs[i].fe;
      instr_ready    = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #1;
      chk($sformatf("vec%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d mem_addr", i),    32'(mem_addr),    32'(vecs[i].emaddr));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d instr_pc", i), 32'(instr_pc), 32'(vecs[i].epc));
        chk($sformatf("vec%0d instr", i),    instr,         ram_word(vecs[i].epc));
      end
      $display("vec %0d: fe=%0d rdy=%0d rv=%0d rpc=%0d -> valid=%0d pc=%0d addr=%0d",
               i, fetch_en, instr_ready, redirect_valid, redirect_pc,
               instr_valid, instr_pc, mem_addr);
      @(negedge clk);
    end

    // Fill the queue, then reset asynchronously between clock edges
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    fetch_en       = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("prefill instr_valid", 32'(instr_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset instr_valid", 32'(instr_valid), 32'd0);
    chk("async reset mem_addr",    32'(mem_addr),    32'd0);
    chk("async reset instr_pc",    32'(instr_pc),    32'd0);
    $display("async reset: valid=%0d addr=%0d", instr_valid, mem_addr);

    // Release and stream 32 instructions back to back
    @(negedge clk);
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k <= 32; k++) begin
      #1;
      if (k == 0) begin
        chk("stream first valid", 32'(instr_valid), 32'd0);
      end else begin
        chk($sformatf("stream%0d instr_valid", k), 32'(instr_valid), 32'd1);
        chk($sformatf("stream%0d instr_pc", k),    32'(instr_pc),    32'(k - 1));
        chk($sformatf("stream%0d instr", k),       instr,            ram_word(6'(k - 1)));
      end
      $display("stream %0d: valid=%0d pc=%0d instr=%08h", k, instr_valid, instr_pc, instr);
      @(negedge clk);
    end

`ifdef IMEM_DBG_PORT_EN
    // Debug read of word 5 mid-stream: one bubble, no PC skipped
    dbg_req  = 1'b1;
    dbg_addr = 6'd5;
    #1;
    chk("dbg cycle mem_addr", 32'(mem_addr), 32'd5);
    chk("dbg cycle instr_pc", 32'(instr_pc), 32'd32);
    @(negedge clk);
    dbg_req = 1'b0;
    #1;
    chk("dbg ack",          32'(dbg_ack),     32'd1);
    chk("dbg data",         dbg_data,         ram_word(6'd5));
    chk("dbg bubble valid", 32'(instr_valid), 32'd0);
    chk("dbg resume addr",  32'(mem_addr),    32'd33);
    $display("dbg: ack=%0d data=%08h", dbg_ack, dbg_data);
    @(negedge clk);
    #1;
    chk("dbg ack one cycle", 32'(dbg_ack),  32'd0);
    chk("post dbg pc 33",    32'(instr_pc), 32'd33);
    chk("post dbg instr",    instr,         ram_word(6'd33));
    @(negedge clk);
    #1;
    chk("post dbg pc 34", 32'(instr_pc), 32'd34);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle-read Inst_memory (6-bit word address, 32-bit combinational read data). It owns the fetch PC, drives the memory address every cycle, and buffers fetched words with their PCs in a small FIFO. It hands instructions to decode over a valid/ready handshake and flushes on a branch/jump redirect. Sits between Inst_memory and the decode stage.

Parameters:
ADDR_W, 6, word-address width; matches Inst_memory depth of 64 words.
DATA_W, 32, instruction width.
DEPTH, 4, prefetch queue entries (power of 2, >=2).
RESET_PC, 0, fetch PC after reset.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
fetch_en  in  1  fetch permitted; 0 = hold fetch PC, no push.
mem_addr  out  ADDR_W  to Inst_memory address.
mem_data  in  DATA_W  from Inst_memory read data, valid the same cycle.
redirect_valid  in  1  flush queue and load new PC.
redirect_pc  in  ADDR_W  redirect target.
instr_valid  out  1  queue head valid.
instr  out  DATA_W  queue head instruction.
instr_pc  out  ADDR_W  PC of queue head.
instr_ready  in  1  decode accepts head.

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, count=0, rd/wr ptrs=0, all entries 0. instr_valid=0, instr=0, instr_pc=0, mem_addr=RESET_PC.
- mem_addr = fetch_pc (combinational from register); with debug feature, see below.
- pop = instr_valid & instr_ready. instr_valid = (count!=0); instr/instr_pc = head entry (combinational from storage).
- push = fetch_en & ~redirect_valid & (count<DEPTH | pop). On push: entry {fetch_pc, mem_data} written at wr_ptr, fetch_pc <= fetch_pc+1.
- count: push&~pop +1; pop&~push -1; both: unchanged (full queue with pop still pushes).
- PC arithmetic modulo 2^ADDR_W: 63 -> 0, no flag.
- Redirect (highest priority): at edge, count<=0, ptrs<=0, fetch_pc<=redirect_pc; no push, pop ignored in that cycle (decode must treat that cycle's head as squashed). Target word pushed next cycle; instr_valid with instr_pc=redirect_pc 2 cycles after the redirect cycle. Redirect held multiple cycles: reloads each cycle, no pushes.
- Throughput: 1 instruction/cycle sustained with instr_ready=1. Latency from reset release: first push cycle 0, instr_valid=1 at cycle 1.
- fetch_en=0: no push, fetch_pc held; queue still drains.
- Reset mid-operation: all state cleared immediately; in-flight entries lost.

Optional Feature:
Macro IMEM_DBG_PORT_EN. When defined, adds ports dbg_req (in, 1), dbg_addr (in, ADDR_W), dbg_data (out, DATA_W, registered), dbg_ack (out, 1). A cycle with dbg_req=1 wins the memory: mem_addr=dbg_addr, push suppressed, fetch_pc held (no address skipped), mem_data captured into dbg_data at the edge, dbg_ack=1 for exactly the following cycle. Redirect in the same cycle still flushes/reloads. Reset: dbg_data=0, dbg_ack=0. When undefined: ports absent, mem_addr=fetch_pc always, no fetch stalls from debug.

Test Plan:
- Reset release, fetch_en=1, instr_ready=1, memfile.dat loaded -> instr_valid=1 from cycle 1; instr_pc 0,1,2,...,31 on consecutive cycles; instr==RAM[instr_pc] every cycle.
- instr_ready=0 for 10 cycles -> count saturates at 4, queue holds PCs 0-3, mem_addr stays 4; instr_ready=1 -> PCs 0,1,2,3,4,5 with no gap cycle.
- Queue holds 3 entries, redirect_valid=1 redirect_pc=0x20 for one cycle -> instr_valid=0 next cycle, instr_pc=0x20 with RAM[0x20] two cycles after redirect, then 0x21.
- Redirect to 62, instr_ready=1 -> instr_pc sequence 62,63,0,1; data matches RAM.
- Full queue with pop each cycle -> push continues, count stays 4; assert rst_n=0 mid-stream -> instr_valid drops immediately (no clock), after release first instr_pc=RESET_PC.
- IMEM_DBG_PORT_EN defined, dbg_req=1 dbg_addr=5 for one cycle mid-stream -> dbg_ack=1 next cycle, dbg_data=RAM[5]; fetch stream delivers contiguous PCs with one bubble, none skipped.
